// File: rtl/traffic_lights_cmd_gen.sv
// Command initiator for the traffic-light controller.
// Accepts one high-level request (CONFIG / OFF / ON / HOLD) over a valid/ready
// handshake and expands it into an ordered train of single-cycle command
// pulses, separated by CMD_GAP_CYCLES idle cycles.
module traffic_lights_cmd_gen #(
   parameter int CMD_GAP_CYCLES = 2,
   parameter int DATA_W         = 16,
   parameter int CMD_W          = 3
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        req_op_i,
   input  logic [DATA_W-1:0] req_green_i,
   input  logic [DATA_W-1:0] req_red_i,
   input  logic [DATA_W-1:0] req_yellow_i,
   output logic [CMD_W-1:0]  cmd_type_o,
   output logic              cmd_valid_o,
   output logic [DATA_W-1:0] cmd_data_o,
   output logic              busy_o
);

   // Gap counter is at least one bit wide even when no gap is configured.
   localparam int GAP_W = (CMD_GAP_CYCLES > 0) ? $clog2(CMD_GAP_CYCLES + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CMD_GAP_CYCLES > 0) ? CMD_GAP_CYCLES - 1 : 0);

   localparam logic [1:0] OP_CONFIG = 2'd0;
   localparam logic [1:0] OP_OFF    = 2'd1;
   localparam logic [1:0] OP_ON     = 2'd2;
   localparam logic [1:0] OP_HOLD   = 2'd3;

   localparam logic [CMD_W-1:0] CMD_ON         = CMD_W'(0);
   localparam logic [CMD_W-1:0] CMD_OFF        = CMD_W'(1);
   localparam logic [CMD_W-1:0] CMD_NOTRANS    = CMD_W'(2);
   localparam logic [CMD_W-1:0] CMD_SET_GREEN  = CMD_W'(3);
   localparam logic [CMD_W-1:0] CMD_SET_RED    = CMD_W'(4);
   localparam logic [CMD_W-1:0] CMD_SET_YELLOW = CMD_W'(5);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND_NT,
      S_SEND_G,
      S_SEND_R,
      S_SEND_Y,
      S_SEND_ON,
      S_SEND_OFF,
      S_GAP
   } state_t;

   state_t             state_q, state_d;
   state_t             target_q, target_d;
   state_t             succ;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [1:0]         op_q;
   logic [DATA_W-1:0]  green_q, red_q, yellow_q;
   logic               cmd_valid_d;
   logic [CMD_W-1:0]   cmd_type_d;
   logic [DATA_W-1:0]  cmd_data_d;
   logic               accept;

   assign req_ready_o = (state_q == S_IDLE);
   assign busy_o      = ~req_ready_o;
   assign accept      = req_valid_i && req_ready_o;

   // State register, gap bookkeeping and registered command outputs.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q     <= S_IDLE;
         target_q    <= S_IDLE;
         gap_cnt_q   <= '0;
         cmd_valid_o <= 1'b0;
         cmd_type_o  <= '0;
         cmd_data_o  <= '0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         gap_cnt_q   <= gap_cnt_d;
         cmd_valid_o <= cmd_valid_d;
         cmd_type_o  <= cmd_type_d;
         cmd_data_o  <= cmd_data_d;
      end
   end

   // Capture the request at acceptance; inputs are ignored afterwards.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         op_q     <= OP_CONFIG;
         green_q  <= '0;
         red_q    <= '0;
         yellow_q <= '0;
      end else if (accept) begin
         op_q     <= req_op_i;
         green_q  <= req_green_i;
         red_q    <= req_red_i;
         yellow_q <= req_yellow_i;
      end
   end

   // Next-state: pick the command following the current pulse, skipping
   // zero-valued SET_* fields, and route through GAP when spacing is needed.
   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      gap_cnt_d = gap_cnt_q;
      succ      = S_IDLE;

      case (state_q)
         S_SEND_NT: begin
            if (op_q == OP_HOLD)     succ = S_IDLE;
            else if (green_q != '0)  succ = S_SEND_G;
            else if (red_q != '0)    succ = S_SEND_R;
            else if (yellow_q != '0) succ = S_SEND_Y;
            else                     succ = S_SEND_ON;
         end
         S_SEND_G: begin
            if (red_q != '0)         succ = S_SEND_R;
            else if (yellow_q != '0) succ = S_SEND_Y;
            else                     succ = S_SEND_ON;
         end
         S_SEND_R: begin
            if (yellow_q != '0)      succ = S_SEND_Y;
            else                     succ = S_SEND_ON;
         end
         S_SEND_Y:                   succ = S_SEND_ON;
         default:                    succ = S_IDLE;
      endcase

      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               case (req_op_i)
                  OP_OFF:  state_d = S_SEND_OFF;
                  OP_ON:   state_d = S_SEND_ON;
                  default: state_d = S_SEND_NT;
               endcase
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = target_q;
            else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
         end
         default: begin
            if (succ == S_IDLE || CMD_GAP_CYCLES == 0) begin
               state_d = succ;
            end else begin
               state_d   = S_GAP;
               target_d  = succ;
               gap_cnt_d = '0;
            end
         end
      endcase
   end

   // Output decode from the next state, so the pulse is flopped into the
   // same cycle the SEND_* state is occupied.
   always_comb begin
      cmd_valid_d = 1'b0;
      cmd_type_d  = '0;
      cmd_data_d  = '0;
      case (state_d)
         S_SEND_NT: begin
            cmd_valid_d = 1'b1;
            cmd_type_d  = CMD_NOTRANS;
         end
         S_SEND_G: begin
            cmd_valid_d = 1'b1;
            cmd_type_d  = CMD_SET_GREEN;
            cmd_data_d  = green_q;
         end
         S_SEND_R: begin
            cmd_valid_d = 1'b1;
            cmd_type_d  = CMD_SET_RED;
            cmd_data_d  = red_q;
         end
         S_SEND_Y: begin
            cmd_valid_d = 1'b1;
            cmd_type_d  = CMD_SET_YELLOW;
            cmd_data_d  = yellow_q;
         end
         S_SEND_ON: begin
            cmd_valid_d = 1'b1;
            cmd_type_d  = CMD_ON;
         end
         S_SEND_OFF: begin
            cmd_valid_d = 1'b1;
            cmd_type_d  = CMD_OFF;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_lights_cmd_gen.sv
// Directed bench for traffic_lights_cmd_gen: a table of requests with their
// expected pulse trains, plus hand-written back-to-back, async-reset and
// zero-gap sequences.
module tb_traffic_lights_cmd_gen;

   localparam int GAP = 2;

   localparam logic [1:0] OP_CONFIG = 2'd0;
   localparam logic [1:0] OP_OFF    = 2'd1;
   localparam logic [1:0] OP_ON     = 2'd2;
   localparam logic [1:0] OP_HOLD   = 2'd3;

   logic        clk_i = 1'b0;
   logic        arst_n_i;
   logic        req_valid_i;
   logic [1:0]  req_op_i;
   logic [15:0] req_green_i, req_red_i, req_yellow_i;

   logic        rdy2, busy2, vld2;
   logic [2:0]  typ2;
   logic [15:0] dat2;
   logic        rdy0, busy0, vld0;
   logic [2:0]  typ0;
   logic [15:0] dat0;

   int checks = 0;
   int errors = 0;

   traffic_lights_cmd_gen #(.CMD_GAP_CYCLES(GAP), .DATA_W(16), .CMD_W(3)) dut (
      .clk_i        (clk_i),
      .arst_n_i     (arst_n_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (rdy2),
      .req_op_i     (req_op_i),
      .req_green_i  (req_green_i),
      .req_red_i    (req_red_i),
      .req_yellow_i (req_yellow_i),
      .cmd_type_o   (typ2),
      .cmd_valid_o  (vld2),
      .cmd_data_o   (dat2),
      .busy_o       (busy2)
   );

   traffic_lights_cmd_gen #(.CMD_GAP_CYCLES(0), .DATA_W(16), .CMD_W(3)) dut0 (
      .clk_i        (clk_i),
      .arst_n_i     (arst_n_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (rdy0),
      .req_op_i     (req_op_i),
      .req_green_i  (req_green_i),
      .req_red_i    (req_red_i),
      .req_yellow_i (req_yellow_i),
      .cmd_type_o   (typ0),
      .cmd_valid_o  (vld0),
      .cmd_data_o   (dat0),
      .busy_o       (busy0)
   );

   always #5 clk_i = ~clk_i;

   // One request and the pulse train it must produce (unused slots are 0).
   typedef struct packed {
      logic [1:0]        op;
      logic [15:0]       g;
      logic [15:0]       r;
      logic [15:0]       y;
      logic [2:0]        n;
      logic [0:4][2:0]   t;
      logic [0:4][15:0]  d;
      logic              noise;
   } vec_t;

   vec_t vecs [8];

   function automatic logic [31:0] obs2();
      return {10'd0, busy2, rdy2, vld2, typ2, dat2};
   endfunction

   function automatic logic [31:0] obs0();
      return {10'd0, busy0, rdy0, vld0, typ0, dat0};
   endfunction

   function automatic logic [31:0] exp_word(input logic v, input logic [2:0] t,
                                            input logic [15:0] d, input logic rdy);
      return {10'd0, ~rdy, rdy, v, t, d};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got busy/rdy/vld/type/data=%h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      req_valid_i = 1'b0;
      arst_n_i    = 1'b0;
      repeat (2) @(negedge clk_i);
      arst_n_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic drive_req(input logic [1:0] op, input logic [15:0] g,
                            input logic [15:0] r, input logic [15:0] y);
      req_valid_i  = 1'b1;
      req_op_i     = op;
      req_green_i  = g;
      req_red_i    = r;
      req_yellow_i = y;
   endtask

   // Issue vecs[idx] on the gap-2 DUT and check every cycle until ready returns.
   task automatic run_vec(input int idx, input int stop_at);
      vec_t v;
      int   last, k;
      logic pulse;
      v    = vecs[idx];
      last = 1 + (int'(v.n) - 1) * (GAP + 1);
      @(negedge clk_i);
      check($sformatf("v%0d accept", idx), obs2(), exp_word(1'b0, 3'd0, 16'd0, 1'b1));
      drive_req(v.op, v.g, v.r, v.y);
      for (int c = 1; c <= last + 1 && c <= stop_at; c++) begin
         @(negedge clk_i);
         k     = (c - 1) / (GAP + 1);
         pulse = ((c - 1) % (GAP + 1) == 0) && (k < int'(v.n));
         if (pulse)
            check($sformatf("v%0d c%0d", idx, c), obs2(), exp_word(1'b1, v.t[k], v.d[k], 1'b0));
         else
            check($sformatf("v%0d c%0d", idx, c), obs2(), exp_word(1'b0, 3'd0, 16'd0, c == last + 1));
         if (v.noise && c <= last)
            drive_req(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         else
            req_valid_i = 1'b0;
      end
   endtask

   initial begin
      vecs[0] = '{op:OP_CONFIG, g:16'd100, r:16'd200, y:16'd30, n:3'd5,
                  t:{3'd2, 3'd3, 3'd4, 3'd5, 3'd0},
                  d:{16'd0, 16'd100, 16'd200, 16'd30, 16'd0}, noise:1'b0};
      vecs[1] = '{op:OP_CONFIG, g:16'd0, r:16'd50, y:16'd0, n:3'd3,
                  t:{3'd2, 3'd4, 3'd0, 3'd0, 3'd0},
                  d:{16'd0, 16'd50, 16'd0, 16'd0, 16'd0}, noise:1'b0};
      vecs[2] = '{op:OP_CONFIG, g:16'd0, r:16'd0, y:16'd0, n:3'd2,
                  t:{3'd2, 3'd0, 3'd0, 3'd0, 3'd0},
                  d:{16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, noise:1'b0};
      vecs[3] = '{op:OP_OFF, g:16'd11, r:16'd22, y:16'd33, n:3'd1,
                  t:{3'd1, 3'd0, 3'd0, 3'd0, 3'd0},
                  d:{16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, noise:1'b0};
      vecs[4] = '{op:OP_ON, g:16'd0, r:16'd0, y:16'd0, n:3'd1,
                  t:{3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                  d:{16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, noise:1'b0};
      vecs[5] = '{op:OP_HOLD, g:16'd5, r:16'd6, y:16'd7, n:3'd1,
                  t:{3'd2, 3'd0, 3'd0, 3'd0, 3'd0},
                  d:{16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, noise:1'b0};
      vecs[6] = '{op:OP_CONFIG, g:16'd0, r:16'd0, y:16'd7, n:3'd3,
                  t:{3'd2, 3'd5, 3'd0, 3'd0, 3'd0},
                  d:{16'd0, 16'd7, 16'd0, 16'd0, 16'd0}, noise:1'b1};
      vecs[7] = '{op:OP_CONFIG, g:16'hFFFF, r:16'd1, y:16'd0, n:3'd4,
                  t:{3'd2, 3'd3, 3'd4, 3'd0, 3'd0},
                  d:{16'd0, 16'hFFFF, 16'd1, 16'd0, 16'd0}, noise:1'b0};

      req_op_i     = OP_CONFIG;
      req_green_i  = '0;
      req_red_i    = '0;
      req_yellow_i = '0;
      do_reset();
      check("reset gap2", obs2(), exp_word(1'b0, 3'd0, 16'd0, 1'b1));
      check("reset gap0", obs0(), exp_word(1'b0, 3'd0, 16'd0, 1'b1));

      // Table-driven requests on the gap-2 instance.
      for (int i = 0; i < 8; i++) run_vec(i, 100);

      // OFF then HOLD with req_valid_i held high across the boundary.
      @(negedge clk_i);
      check("b2b accept", obs2(), exp_word(1'b0, 3'd0, 16'd0, 1'b1));
      drive_req(OP_OFF, 16'd9, 16'd9, 16'd9);
      @(negedge clk_i);
      check("b2b off pulse", obs2(), exp_word(1'b1, 3'd1, 16'd0, 1'b0));
      drive_req(OP_HOLD, 16'd8, 16'd8, 16'd8);
      @(negedge clk_i);
      check("b2b ready", obs2(), exp_word(1'b0, 3'd0, 16'd0, 1'b1));
      @(negedge clk_i);
      check("b2b hold pulse", obs2(), exp_word(1'b1, 3'd2, 16'd0, 1'b0));
      req_valid_i = 1'b0;
      @(negedge clk_i);
      check("b2b idle", obs2(), exp_word(1'b0, 3'd0, 16'd0, 1'b1));

      // Async reset in the middle of the SET_RED pulse (cycle 7 of vecs[0]).
      run_vec(0, 7);
      #1 arst_n_i = 1'b0;
      #1 check("async reset clear", obs2(), exp_word(1'b0, 3'd0, 16'd0, 1'b1));
      @(negedge clk_i);
      arst_n_i = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk_i);
         check($sformatf("post-reset quiet c%0d", c), obs2(), exp_word(1'b0, 3'd0, 16'd0, 1'b1));
      end
      run_vec(4, 100);

      // Zero-gap instance: five back-to-back pulses.
      do_reset();
      check("gap0 accept", obs0(), exp_word(1'b0, 3'd0, 16'd0, 1'b1));
      drive_req(OP_CONFIG, 16'd1, 16'd2, 16'd3);
      for (int c = 1; c <= 6; c++) begin
         logic [2:0]  et;
         logic [15:0] ed;
         @(negedge clk_i);
         req_valid_i = 1'b0;
         case (c)
            1: begin et = 3'd2; ed = 16'd0; end
            2: begin et = 3'd3; ed = 16'd1; end
            3: begin et = 3'd4; ed = 16'd2; end
            4: begin et = 3'd5; ed = 16'd3; end
            default: begin et = 3'd0; ed = 16'd0; end
         endcase
         if (c <= 5)
            check($sformatf("gap0 c%0d", c), obs0(), exp_word(1'b1, et, ed, 1'b0));
         else
            check("gap0 ready", obs0(), exp_word(1'b0, 3'd0, 16'd0, 1'b1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
